hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
// - Parametrised successor of the pipeline forwarding/hazard unit. Sits beside the ID stage of the
//   5-stage RV32 core.
// - Forwards EX/MEM/WB results onto NRP register-file read ports.
// - Detects load-use hazards for a data memory with LD_LAT cycles of load latency.
// - Runs a bubble counter that stalls IF/ID and bubbles EX for exactly the required cycles.
// - Keeps saturating performance counters for hazard events, stall cycles and forwards.
// PARAMETERS
// - XLEN   32  data width.
// - NRP    2   number of ID read ports, 1..4.
// - LD_LAT 1   load-data latency: 1 = rd valid in MEM; 2 = rd valid only in WB. Legal values 1..2.
// - CNT_W  32  width of the performance counters.
// PORTS
// clk          in   1         core clock
// rst_n        in   1         async active-low reset
// id_rR        in   NRP*5     ID source register indices, port k at [5k+4:5k]
// id_rf_re     in   NRP       per-port read enable
// id_rD        in   NRP*XLEN  register-file read data
// ex_wR        in   5         EX destination register
// ex_rf_we     in   1         EX write enable
// ex_rf_wsel   in   2         EX write-back select (`S_* encodings)
// ex_wD        in   XLEN      EX non-load result, already muxed from pc4/ext/alu_c
// mem_wR       in   5         MEM destination register
// mem_rf_we    in   1         MEM write enable
// mem_rf_wsel  in   2         MEM write-back select
// mem_wD       in   XLEN      MEM non-load result
// mem_rd       in   XLEN      MEM load data (ignored when LD_LAT=2)
// wb_wR        in   5         WB destination register
// wb_rf_we     in   1         WB write enable
// wb_wD        in   XLEN      WB final write data, load data included
// flush        in   1         branch/jump redirect; kills ID
// cnt_clr      in   1         synchronous clear of the performance counters
// new_rD       out  NRP*XLEN  forwarded operands
// stall        out  1         hold PC and IF/ID
// bubble_ex    out  1         insert NOP into ID/EX (equals stall)
// ldu_evt_cnt  out  CNT_W     load-use events
// stall_cyc_cnt out CNT_W     stall cycles
// fwd_cnt      out  CNT_W     cycles with at least one forwarded operand
// BEHAVIOUR
// - Match, per port k and stage s: rR_k == s_wR, s_rf_we, id_rf_re[k], and rR_k != 0.
//   Priority EX > MEM > WB > id_rD.
// - Forward value from EX is ex_wD. MEM gives mem_rd if wsel==`S_DRAM_rd, else mem_wD. WB gives wb_wD.
//   The output is fully combinational.
// - need (bubbles required), taking the maximum over all ports:
//   - EX match with wsel==`S_DRAM_rd: need = LD_LAT.
//   - MEM match with wsel==`S_DRAM_rd and LD_LAT==2: need = 1.
//   - Otherwise need = 0.
// - bub_cnt register (2b, reset 0):
//   - When bub_cnt==0 and need>0: stall=1, bub_cnt <= need-1, ldu_evt_cnt += 1.
//   - When bub_cnt!=0: stall=1, bub_cnt <= bub_cnt-1. Detection is ignored, so no second event is counted.
//   - stall = (bub_cnt!=0) | (bub_cnt==0 & need>0). bubble_ex = stall.
// - flush has priority: bub_cnt <= 0 and stall=0 in that cycle. Any event detected in the same cycle is not counted.
// - Counters saturate at all-ones. cnt_clr zeroes all three; if cnt_clr coincides with an increment, the result is 0.
// - stall_cyc_cnt += stall. fwd_cnt += 1 when any port selects a non-ID source and flush=0.
// - Reset (async, rst_n=0): bub_cnt, all counters and stall = 0. new_rD follows its combinational
//   inputs. Reset asserted mid-stall aborts the stall immediately.
// STRUCTURE
// - Shared package defines.vh holds `S_PC4, `S_SEXT_ext, `S_ALU_C and `S_DRAM_rd.
// - Sub-module fwd_mux: one instance per read port via generate. It owns the 3-stage compare,
//   the priority select and that port's need contribution.
// - The top level owns the need max, bub_cnt and the counters.
// TESTING
// - LD_LAT=1: load x5 in EX, add reading x5 in ID -> stall=1 for 1 cycle, then new_rD = mem_rd = 0xDEADBEEF,
//   ldu_evt_cnt=1.
// - LD_LAT=2, same sequence -> stall for 2 consecutive cycles, ldu_evt_cnt=1 (not 2), stall_cyc_cnt=2,
//   then operand = wb_wD.
// - x3 written by EX (0x11), MEM (0x22) and WB (0x33) at once -> new_rD = 0x11. Reading x0 with a
//   stage writing x0 -> id_rD unchanged.
// - NRP=3: port 0 load-use on EX, port 2 ALU match on WB -> stall=1; port 2 gets wb_wD, port 1 gets id_rD.
// - LD_LAT=2, flush on the 1st stall cycle -> stall=0 in that cycle and after, bub_cnt=0.
//   rst_n pulsed mid-stall -> everything is 0 asynchronously.
// - Force stall_cyc_cnt to all-ones, then stall again -> value holds. cnt_clr coinciding with an event -> all counters 0.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the ID-stage forwarding / load-use hazard unit:
// write-back select encodings and the per-port bubble requirement helper.
package hazard_fwd_ctrl_pkg;

   localparam logic [1:0] S_PC4      = 2'd0;
   localparam logic [1:0] S_SEXT_EXT = 2'd1;
   localparam logic [1:0] S_ALU_C    = 2'd2;
   localparam logic [1:0] S_DRAM_RD  = 2'd3;

   // A load still in MEM only hurts when its data arrives in WB.
   function automatic logic [1:0] need_calc(input logic       ex_load_hit,
                                            input logic       mem_load_hit,
                                            input logic [1:0] ld_lat);
      logic [1:0] n;
      if (ex_load_hit) begin
         n = ld_lat;
      end else if (mem_load_hit && (ld_lat == 2'd2)) begin
         n = 2'd1;
      end else begin
         n = 2'd0;
      end
      return n;
   endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle of pipeline-stage inputs and forwarding/stall/counter outputs of the
// hazard unit; slave is the hazard unit, master is the surrounding core.
interface hazard_fwd_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int NRP   = 2,
   parameter int CNT_W = 32
);
   logic [NRP*5-1:0]    id_rR;
   logic [NRP-1:0]      id_rf_re;
   logic [NRP*XLEN-1:0] id_rD;
   logic [4:0]          ex_wR;
   logic                ex_rf_we;
   logic [1:0]          ex_rf_wsel;
   logic [XLEN-1:0]     ex_wD;
   logic [4:0]          mem_wR;
   logic                mem_rf_we;
   logic [1:0]          mem_rf_wsel;
   logic [XLEN-1:0]     mem_wD;
   logic [XLEN-1:0]     mem_rd;
   logic [4:0]          wb_wR;
   logic                wb_rf_we;
   logic [XLEN-1:0]     wb_wD;
   logic                flush;
   logic                cnt_clr;
   logic [NRP*XLEN-1:0] new_rD;
   logic                stall;
   logic                bubble_ex;
   logic [CNT_W-1:0]    ldu_evt_cnt;
   logic [CNT_W-1:0]    stall_cyc_cnt;
   logic [CNT_W-1:0]    fwd_cnt;

   modport slave (
      input  id_rR, id_rf_re, id_rD,
      input  ex_wR, ex_rf_we, ex_rf_wsel, ex_wD,
      input  mem_wR, mem_rf_we, mem_rf_wsel, mem_wD, mem_rd,
      input  wb_wR, wb_rf_we, wb_wD,
      input  flush, cnt_clr,
      output new_rD, stall, bubble_ex, ldu_evt_cnt, stall_cyc_cnt, fwd_cnt
   );

   modport master (
      output id_rR, id_rf_re, id_rD,
      output ex_wR, ex_rf_we, ex_rf_wsel, ex_wD,
      output mem_wR, mem_rf_we, mem_rf_wsel, mem_wD, mem_rd,
      output wb_wR, wb_rf_we, wb_wD,
      output flush, cnt_clr,
      input  new_rD, stall, bubble_ex, ldu_evt_cnt, stall_cyc_cnt, fwd_cnt
   );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_mux.sv
// One register read port: EX/MEM/WB match, priority operand select and the
// number of bubbles this port needs before its operand becomes available.
module hazard_fwd_ctrl_fwd_mux
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int LD_LAT = 1
) (
   input  logic [4:0]      rr,
   input  logic            re,
   input  logic [XLEN-1:0] rd,
   input  logic [4:0]      ex_wr,
   input  logic            ex_we,
   input  logic [1:0]      ex_wsel,
   input  logic [XLEN-1:0] ex_wd,
   input  logic [4:0]      mem_wr,
   input  logic            mem_we,
   input  logic [1:0]      mem_wsel,
   input  logic [XLEN-1:0] mem_wd,
   input  logic [XLEN-1:0] mem_rd,
   input  logic [4:0]      wb_wr,
   input  logic            wb_we,
   input  logic [XLEN-1:0] wb_wd,
   output logic [XLEN-1:0] new_rd,
   output logic            fwd,
   output logic [1:0]      need
);

   logic port_live_s;
   logic ex_hit_s;
   logic mem_hit_s;
   logic wb_hit_s;

   assign port_live_s = re && (rr != 5'd0);
   assign ex_hit_s    = port_live_s && ex_we  && (rr == ex_wr);
   assign mem_hit_s   = port_live_s && mem_we && (rr == mem_wr);
   assign wb_hit_s    = port_live_s && wb_we  && (rr == wb_wr);

   // Youngest producer wins; load data from MEM only exists when LD_LAT is 1.
   always_comb begin
      new_rd = rd;
      fwd    = 1'b0;
      if (ex_hit_s) begin
         new_rd = ex_wd;
         fwd    = 1'b1;
      end else if (mem_hit_s) begin
         new_rd = ((LD_LAT == 1) && (mem_wsel == S_DRAM_RD)) ? mem_rd : mem_wd;
         fwd    = 1'b1;
      end else if (wb_hit_s) begin
         new_rd = wb_wd;
         fwd    = 1'b1;
      end else begin
         new_rd = rd;
         fwd    = 1'b0;
      end
   end

   assign need = need_calc(ex_hit_s && (ex_wsel == S_DRAM_RD),
                           !ex_hit_s && mem_hit_s && (mem_wsel == S_DRAM_RD),
                           2'(LD_LAT));

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID-stage forwarding and load-use hazard unit: per-port forwarding muxes,
// bubble counter driving stall/bubble_ex, and saturating performance counters.
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NRP    = 2,
   parameter int LD_LAT = 1,
   parameter int CNT_W  = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   hazard_fwd_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       need_s [NRP];
   logic [NRP-1:0]   fwd_vec_s;
   logic [1:0]       need_max_s;
   logic [1:0]       bub_cnt_r;
   logic [1:0]       bub_nxt_s;
   logic             stall_s;
   logic             evt_s;
   logic             fwd_any_s;
   logic [CNT_W-1:0] ldu_cnt_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] fwd_cnt_r;

   genvar k;
   generate
      for (k = 0; k < NRP; k++) begin : g_port
         hazard_fwd_ctrl_fwd_mux #(
            .XLEN   (XLEN),
            .LD_LAT (LD_LAT)
         ) u_mux (
            .rr       (bus.id_rR[5*k +: 5]),
            .re       (bus.id_rf_re[k]),
            .rd       (bus.id_rD[XLEN*k +: XLEN]),
            .ex_wr    (bus.ex_wR),
            .ex_we    (bus.ex_rf_we),
            .ex_wsel  (bus.ex_rf_wsel),
            .ex_wd    (bus.ex_wD),
            .mem_wr   (bus.mem_wR),
            .mem_we   (bus.mem_rf_we),
            .mem_wsel (bus.mem_rf_wsel),
            .mem_wd   (bus.mem_wD),
            .mem_rd   (bus.mem_rd),
            .wb_wr    (bus.wb_wR),
            .wb_we    (bus.wb_rf_we),
            .wb_wd    (bus.wb_wD),
            .new_rd   (bus.new_rD[XLEN*k +: XLEN]),
            .fwd      (fwd_vec_s[k]),
            .need     (need_s[k])
         );
      end
   endgenerate

   // Worst-case bubble requirement over all read ports.
   always_comb begin
      need_max_s = 2'd0;
      for (int i = 0; i < NRP; i++) begin
         if (need_s[i] > need_max_s) begin
            need_max_s = need_s[i];
         end else begin
            need_max_s = need_max_s;
         end
      end
   end

   // Bubble counter next state; while counting down, new detections are ignored.
   always_comb begin
      bub_nxt_s = 2'd0;
      stall_s   = 1'b0;
      evt_s     = 1'b0;
      if (bus.flush) begin
         bub_nxt_s = 2'd0;
      end else if (bub_cnt_r != 2'd0) begin
         stall_s   = 1'b1;
         bub_nxt_s = bub_cnt_r - 2'd1;
      end else if (need_max_s != 2'd0) begin
         stall_s   = 1'b1;
         evt_s     = 1'b1;
         bub_nxt_s = need_max_s - 2'd1;
      end else begin
         bub_nxt_s = 2'd0;
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bub_cnt_r <= 2'd0;
      end else begin
         bub_cnt_r <= bub_nxt_s;
      end
   end

   assign fwd_any_s = (|fwd_vec_s) && !bus.flush;

   // Saturating performance counters; a clear beats a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ldu_cnt_r   <= {CNT_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
         fwd_cnt_r   <= {CNT_W{1'b0}};
      end else if (bus.cnt_clr) begin
         ldu_cnt_r   <= {CNT_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
         fwd_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         if (evt_s && (ldu_cnt_r != CNT_MAX)) ldu_cnt_r <= ldu_cnt_r + CNT_ONE;
         if (stall_s && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
         if (fwd_any_s && (fwd_cnt_r != CNT_MAX)) fwd_cnt_r <= fwd_cnt_r + CNT_ONE;
      end
   end

   // Reset kills an in-progress stall without waiting for a clock edge.
   assign bus.stall         = stall_s && rst_n;
   assign bus.bubble_ex     = stall_s && rst_n;
   assign bus.ldu_evt_cnt   = ldu_cnt_r;
   assign bus.stall_cyc_cnt = stall_cnt_r;
   assign bus.fwd_cnt       = fwd_cnt_r;

endmodule
